// File: rtl/i2s_codec_target.sv
// I2S target (codec side). Follows an externally driven sclk/lrclk pair,
// deserialises sdin into per-channel 24-bit words and serialises the
// per-channel transmit words onto sdout. All logic runs on clk; every I2S pin
// is brought into the clk domain through a two-flop synchroniser.
module i2s_codec_target #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2s_rstn,
  input  logic              i2s_lrclk,
  input  logic              i2s_sclk,
  input  logic              i2s_sdin,
  output logic              i2s_sdout,
  output logic [1:0]        rx_vld,
  output logic [DATA_W-1:0] rx_data,
  input  logic [DATA_W-1:0] tx_data0,
  input  logic [DATA_W-1:0] tx_data1,
  output logic [1:0]        tx_ack,
  output logic              frame_err,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(SLOT_W + 1);
  localparam int TXC_W = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, SLOT} state_t;

  logic [1:0] rstn_sync;
  logic [1:0] lr_sync;
  logic [1:0] sclk_sync;
  logic [1:0] sdin_sync;
  logic       sclk_d;

  logic rstn_s;
  logic lr_s;
  logic sclk_s;
  logic sdin_s;
  logic sclk_rise;
  logic sclk_fall;

  state_t            state;
  logic              lr_q;
  logic              lr_seen;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_inc;
  logic [TXC_W-1:0]  tx_cnt;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_sr;
  logic              boundary;

  // Two-flop synchronisers for every pin plus one extra sclk stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstn_sync <= '0;
      lr_sync   <= '0;
      sclk_sync <= '0;
      sdin_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      rstn_sync <= {rstn_sync[0], i2s_rstn};
      lr_sync   <= {lr_sync[0], i2s_lrclk};
      sclk_sync <= {sclk_sync[0], i2s_sclk};
      sdin_sync <= {sdin_sync[0], i2s_sdin};
      sclk_d    <= sclk_sync[1];
    end
  end

  assign rstn_s    = rstn_sync[1];
  assign lr_s      = lr_sync[1];
  assign sclk_s    = sclk_sync[1];
  assign sdin_s    = sdin_sync[1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  // A boundary needs a previously captured lrclk so the first rise after reset only primes lr_q
  assign boundary = lr_seen && (lr_s != lr_q);
  assign bit_inc  = (bit_cnt == CNT_W'(SLOT_W)) ? bit_cnt : bit_cnt + 1'b1;
  assign rx_next  = {rx_sr[DATA_W-2:0], sdin_s};

  // Slot sequencer: tracks lrclk, counts bits, shifts data in on rises and out on falls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lr_q      <= 1'b0;
      lr_seen   <= 1'b0;
      bit_cnt   <= '0;
      tx_cnt    <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      i2s_sdout <= 1'b0;
      rx_vld    <= '0;
      tx_ack    <= '0;
      rx_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_vld <= '0;
      tx_ack <= '0;
      if (err_clr) begin
        frame_err <= 1'b0;
      end
      if (sclk_rise) begin
        lr_q    <= lr_s;
        lr_seen <= 1'b1;
      end
      if (!rstn_s) begin
        state     <= IDLE;
        i2s_sdout <= 1'b0;
        rx_sr     <= '0;
        tx_sr     <= '0;
        bit_cnt   <= '0;
        tx_cnt    <= '0;
      end else begin
        if (tx_ack != 2'b00) begin
          tx_sr <= tx_ack[1] ? tx_data1 : tx_data0;
        end
        case (state)
          IDLE: begin
            i2s_sdout <= 1'b0;
            if (sclk_rise && boundary) begin
              state   <= SLOT;
              bit_cnt <= '0;
              tx_cnt  <= '0;
              tx_ack  <= {lr_s, ~lr_s};
            end
          end
          SLOT: begin
            if (sclk_rise) begin
              if (boundary) begin
                bit_cnt <= '0;
                tx_cnt  <= '0;
                tx_ack  <= {lr_s, ~lr_s};
                if (bit_cnt < CNT_W'(DATA_W)) begin
                  frame_err <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_inc;
                if (bit_inc <= CNT_W'(DATA_W)) begin
                  rx_sr <= rx_next;
                end
                if (bit_inc == CNT_W'(DATA_W)) begin
                  rx_data <= rx_next;
                  rx_vld  <= {lr_q, ~lr_q};
                end
              end
            end
            if (sclk_fall) begin
              if (tx_cnt < TXC_W'(DATA_W)) begin
                i2s_sdout <= tx_sr[DATA_W-1];
                tx_sr     <= {tx_sr[DATA_W-2:0], 1'b0};
                tx_cnt    <= tx_cnt + 1'b1;
              end else begin
                i2s_sdout <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_codec_target.sv
// Self-checking bench for i2s_codec_target: an I2S master model drives
// sclk/lrclk/sdin slot by slot, checks sdout bit by bit, and pushes the
// expected rx words and tx_ack pulses into queues popped by a monitor.
module tb_i2s_codec_target;

  localparam int DATA_W = 24;
  localparam int SLOT_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i2s_rstn = 1'b1;
  logic              i2s_lrclk = 1'b0;
  logic              i2s_sclk = 1'b0;
  logic              master_sdin = 1'b0;
  logic              loopback = 1'b0;
  logic              sdin_pin;
  logic              i2s_sdout;
  logic [1:0]        rx_vld;
  logic [DATA_W-1:0] rx_data;
  logic [DATA_W-1:0] tx_data0 = '0;
  logic [DATA_W-1:0] tx_data1 = '0;
  logic [1:0]        tx_ack;
  logic              frame_err;
  logic              err_clr = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int half_p = 5;
  int next_ch = 0;
  bit mon_on = 1'b0;

  // Slot-level reference model of the target
  bit lr_known = 1'b0;
  int lr_model = 0;
  bit slot_active = 1'b0;
  int prev_len = 0;
  bit err_model = 1'b0;

  logic [DATA_W-1:0] rx_exp_data[$];
  int                rx_exp_ch[$];
  int                tx_exp_ch[$];
  int                mon_ch;
  logic [DATA_W-1:0] mon_data;

  assign sdin_pin = loopback ? i2s_sdout : master_sdin;

  i2s_codec_target #(.DATA_W(DATA_W), .SLOT_W(SLOT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i2s_rstn  (i2s_rstn),
    .i2s_lrclk (i2s_lrclk),
    .i2s_sclk  (i2s_sclk),
    .i2s_sdin  (sdin_pin),
    .i2s_sdout (i2s_sdout),
    .rx_vld    (rx_vld),
    .rx_data   (rx_data),
    .tx_data0  (tx_data0),
    .tx_data1  (tx_data1),
    .tx_ack    (tx_ack),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the expected response whenever the target presents a pulse
  always @(negedge clk) begin
    if (mon_on) begin
      if (rx_vld !== 2'b00) begin
        if (rx_exp_ch.size() == 0) begin
          checkOutput("unexpected rx_vld", {30'd0, rx_vld}, 32'd0);
        end else begin
          mon_ch   = rx_exp_ch.pop_front();
          mon_data = rx_exp_data.pop_front();
          checkOutput("rx_vld channel", {30'd0, rx_vld}, 32'd1 << mon_ch);
          checkOutput("rx_data", {8'd0, rx_data}, {8'd0, mon_data});
        end
      end
      if (tx_ack !== 2'b00) begin
        if (tx_exp_ch.size() == 0) begin
          checkOutput("unexpected tx_ack", {30'd0, tx_ack}, 32'd0);
        end else begin
          mon_ch = tx_exp_ch.pop_front();
          checkOutput("tx_ack channel", {30'd0, tx_ack}, 32'd1 << mon_ch);
        end
      end
    end
  end

  // Master model: one slot of len sclk periods on channel ch; rst_at >= 0 pulses rst at that bit
  task automatic applyStimulus(input int ch, input int len, input logic [DATA_W-1:0] rx_word,
                               input logic [DATA_W-1:0] tx_word, input int rst_at);
    bit active;
    bit bnd;
    logic exp_bit;
    if (ch == 0) tx_data0 = tx_word;
    else         tx_data1 = tx_word;
    bnd = lr_known && (ch != lr_model);
    if (!i2s_rstn) begin
      slot_active = 1'b0;
    end else if (bnd) begin
      if (slot_active && (prev_len - 1 < DATA_W)) err_model = 1'b1;
      slot_active = 1'b1;
      tx_exp_ch.push_back(ch);
    end
    lr_known = 1'b1;
    lr_model = ch;
    active   = slot_active;
    if (active && rst_at < 0 && len - 1 >= DATA_W) begin
      rx_exp_ch.push_back(ch);
      rx_exp_data.push_back(loopback ? tx_word : rx_word);
    end
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      i2s_sclk = 1'b0;
      if (i == 0) i2s_lrclk = (ch == 1);
      master_sdin = (i >= 1 && i <= DATA_W) ? rx_word[DATA_W-i] : 1'($urandom_range(0, 1));
      if (i == rst_at) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        active      = 1'b0;
        slot_active = 1'b0;
        err_model   = 1'b0;
        repeat (half_p - 3) @(negedge clk);
      end else begin
        repeat (half_p - 1) @(negedge clk);
      end
      @(negedge clk);
      i2s_sclk = 1'b1;
      if (i >= 1) begin
        exp_bit = (active && i <= DATA_W) ? tx_word[DATA_W-i] : 1'b0;
        checkOutput($sformatf("sdout ch%0d bit %0d", ch, i), {31'd0, i2s_sdout}, {31'd0, exp_bit});
      end
      repeat (half_p - 1) @(negedge clk);
    end
    prev_len = len;
    checkOutput("frame_err", {31'd0, frame_err}, {31'd0, err_model});
  endtask

  task automatic doSlot(input int len, input int rst_at);
    applyStimulus(next_ch, len, 24'($urandom), 24'($urandom), rst_at);
    next_ch ^= 1;
  endtask

  // Main sequence
  initial begin
    repeat (5) @(negedge clk);
    checkOutput("reset sdout", {31'd0, i2s_sdout}, 32'd0);
    checkOutput("reset rx_vld", {30'd0, rx_vld}, 32'd0);
    checkOutput("reset tx_ack", {30'd0, tx_ack}, 32'd0);
    checkOutput("reset rx_data", {8'd0, rx_data}, 32'd0);
    checkOutput("reset frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (3) @(negedge clk);

    // Prime lrclk, then the directed words
    applyStimulus(1, 32, 24'h0, 24'h0, -1);
    applyStimulus(0, 32, 24'hABCDEF, 24'h800001, -1);
    checkOutput("directed rx_data L", {8'd0, rx_data}, 32'h00ABCDEF);
    applyStimulus(1, 32, 24'h123456, 24'h7FFFFE, -1);
    checkOutput("directed rx_data R", {8'd0, rx_data}, 32'h00123456);
    next_ch = 0;

    // Random full slots
    repeat (6) doSlot(32, -1);

    // Short slot, following slot flags the error, then clear
    doSlot(20, -1);
    doSlot(32, -1);
    checkOutput("frame_err after short slot", {31'd0, frame_err}, 32'd1);
    doSlot(32, -1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    err_model = 1'b0;
    @(negedge clk);
    checkOutput("frame_err after err_clr", {31'd0, frame_err}, 32'd0);

    // Loopback frames
    loopback = 1'b1;
    repeat (6) doSlot(32, -1);
    loopback = 1'b0;

    // Async reset mid-slot at bit 10
    doSlot(32, 10);
    repeat (3) doSlot(32, -1);

    // Codec reset held low for two slots
    i2s_rstn = 1'b0;
    repeat (2) doSlot(32, -1);
    i2s_rstn = 1'b1;
    repeat (3) doSlot(32, -1);

    // sclk at clk/8 with 48-bit slots
    half_p = 4;
    repeat (4) doSlot(48, -1);
    half_p = 5;

    // Random slot lengths that still carry a full word
    repeat (6) doSlot(int'($urandom_range(25, 40)), -1);
    doSlot(32, -1);

    repeat (20) @(negedge clk);
    checkOutput("rx queue drained", rx_exp_ch.size(), 32'd0);
    checkOutput("tx queue drained", tx_exp_ch.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
